display_scan_controller: RTL and testbench



---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scan_controller_if.sv | 42 ++++
 rtl/scan_prescaler.sv | 45 ++++
 rtl/display_scan_controller.sv | 123 ++++++++++++
 tb/tb_display_scan_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared encodings for the four-digit display scan datapath.
//               Defines digit-select codes, source-select codes and the
//               source FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Digit select codes, in scan order.
  localparam logic [1:0] DIG_SIGN = 2'b00;
  localparam logic [1:0] DIG_HUND = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;
  localparam logic [1:0] DIG_UNIT = 2'b11;

  // Source select codes.
  localparam logic SRC_INPUT  = 1'b0;
  localparam logic SRC_RESULT = 1'b1;

  // The state encoding is the source-select value itself, so the select
  // output is the state register with no decode.
  typedef enum logic [0:0] {
    SHOW_INPUT  = SRC_INPUT,
    SHOW_RESULT = SRC_RESULT
  } src_state_e;

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_if
// Description : Event/data/select bundle of the display scan controller.
//               master : calculator side, drives pulses and digit data,
//                        observes selects and blanking.
//               slave  : scan controller, consumes pulses and data,
//                        drives selects, blank and scan tick.
//               Signals: entry_event, result_valid, clear (1-cycle pulses);
//                        ab_msd[3:0], alu_out_hi[7:0], input_sign, alu_sign;
//                        four_to_one_sel[1:0], two_to_one_sel, digit_blank,
//                        scan_tick.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_if;

  logic       entry_event;
  logic       result_valid;
  logic       clear;
  logic [3:0] ab_msd;
  logic [7:0] alu_out_hi;
  logic       input_sign;
  logic       alu_sign;
  logic [1:0] four_to_one_sel;
  logic       two_to_one_sel;
  logic       digit_blank;
  logic       scan_tick;

  modport master (
    output entry_event, result_valid, clear, ab_msd, alu_out_hi,
           input_sign, alu_sign,
    input  four_to_one_sel, two_to_one_sel, digit_blank, scan_tick
  );

  modport slave (
    input  entry_event, result_valid, clear, ab_msd, alu_out_hi,
           input_sign, alu_sign,
    output four_to_one_sel, two_to_one_sel, digit_blank, scan_tick
  );

endinterface : display_scan_if
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Modulo-TICK_DIV free-running counter.
//               clk   : system clock
//               reset : synchronous active-high reset (count -> 0)
//               count : current count, 0..TICK_DIV-1
//               tick  : high while count == TICK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (count_q == LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = (count_q == LAST);

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_controller
// Description : Four-digit multiplexed 7-segment scan sequencer.
//               Steps the digit select (sign, hundreds, tens, units) once per
//               TICK_DIV cycles, picks operand-entry or ALU-result source
//               with a two-state FSM, and blanks the current digit for dead
//               time, leading zeros and a positive sign.
//               clk   : system clock
//               reset : synchronous active-high reset
//               bus   : display_scan_if.slave (pulses, digit data, selects,
//                       digit_blank, scan_tick)
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_controller
  import display_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  display_scan_if.slave        bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count;
  logic             tick;

  scan_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .tick  (tick)
  );

  // ---------------------------------------------------------------- digit
  logic [1:0] sel_q;
  logic [1:0] sel_d;

  // 2-bit increment wraps units back to sign on its own.
  always_comb begin
    sel_d = sel_q;
    if (tick) begin
      sel_d = sel_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------- source FSM
  src_state_e state_q;
  src_state_e state_d;

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = SHOW_INPUT;
    end else if (bus.result_valid) begin
      state_d = SHOW_RESULT;
    end else if (bus.entry_event && (state_q == SHOW_RESULT)) begin
      state_d = SHOW_INPUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= DIG_SIGN;
      state_q <= SHOW_INPUT;
    end else begin
      sel_q   <= sel_d;
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- blanking
  logic       in_dead;
  logic [3:0] hund;
  logic [3:0] tens;
  logic       sign;
  logic       blank;

  // With no dead time the comparison disappears entirely rather than
  // comparing an unsigned count against zero.
  if (DEAD_CYCLES > 0) begin : g_dead
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);
    assign in_dead = (count < DEAD_LIM);
  end else begin : g_no_dead
    assign in_dead = 1'b0;
  end

  always_comb begin
    hund = 4'd0;
    tens = bus.ab_msd;
    sign = bus.input_sign;
    if (state_q == SHOW_RESULT) begin
      hund = bus.alu_out_hi[7:4];
      tens = bus.alu_out_hi[3:0];
      sign = bus.alu_sign;
    end
  end

  // Units digit is never zero-suppressed; tens is only suppressed when the
  // hundreds digit is also zero, so interior zeros stay visible.
  always_comb begin
    blank = in_dead;
    unique case (sel_q)
      DIG_SIGN: if (!sign)                          blank = 1'b1;
      DIG_HUND: if (hund == 4'd0)                   blank = 1'b1;
      DIG_TENS: if ((hund == 4'd0) && (tens == 4'd0)) blank = 1'b1;
      default:  ;
    endcase
  end

  assign bus.four_to_one_sel = sel_q;
  assign bus.two_to_one_sel  = state_q;
  assign bus.digit_blank     = blank;
  assign bus.scan_tick       = tick;

endmodule : display_scan_controller
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_controller
// Description : Self-checking bench for display_scan_controller with
//               TICK_DIV=8, DEAD_CYCLES=2. A cycle-level reference model
//               pushes expected outputs into a scoreboard queue; a monitor on
//               the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_controller;

  localparam int TICK_DIV    = 8;
  localparam int DEAD_CYCLES = 2;

  logic clk;
  logic reset;

  display_scan_if bus ();

  display_scan_controller #(
    .TICK_DIV    (TICK_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic       src;
    logic       blank;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: cycles elapsed since reset plus the displayed source.
  int   m_cyc;
  logic m_res;

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (bus.four_to_one_sel !== e.sel) begin
        n_fail++;
        $display("FAIL sel cyc=%0d got=%b exp=%b", e.cyc, bus.four_to_one_sel, e.sel);
      end
      n_tests++;
      if (bus.two_to_one_sel !== e.src) begin
        n_fail++;
        $display("FAIL src cyc=%0d got=%b exp=%b", e.cyc, bus.two_to_one_sel, e.src);
      end
      n_tests++;
      if (bus.digit_blank !== e.blank) begin
        n_fail++;
        $display("FAIL blank cyc=%0d sel=%b got=%b exp=%b", e.cyc, e.sel, bus.digit_blank, e.blank);
      end
      n_tests++;
      if (bus.scan_tick !== e.tick) begin
        n_fail++;
        $display("FAIL tick cyc=%0d got=%b exp=%b", e.cyc, bus.scan_tick, e.tick);
      end
    end
  end

  // ------------------------------------------------------------ one cycle
  // Called just after a rising edge: drives this cycle's inputs, predicts
  // this cycle's outputs, then advances the model across the next edge.
  task automatic step(input logic rst, input logic ev, input logic rv,
                      input logic clr, input logic [3:0] msd,
                      input logic [7:0] alu, input logic isg, input logic asg);
    exp_t e;
    int   pos, dig;
    int   h, t, s;
    reset                = rst;
    bus.entry_event      = ev;
    bus.result_valid     = rv;
    bus.clear            = clr;
    bus.ab_msd           = msd;
    bus.alu_out_hi       = alu;
    bus.input_sign       = isg;
    bus.alu_sign         = asg;

    pos = m_cyc % TICK_DIV;
    dig = (m_cyc / TICK_DIV) % 4;
    h   = m_res ? int'(alu[7:4]) : 0;
    t   = m_res ? int'(alu[3:0]) : int'(msd);
    s   = m_res ? int'(asg) : int'(isg);

    e.cyc   = m_cyc;
    e.sel   = 2'(dig);
    e.src   = m_res;
    e.tick  = (pos == TICK_DIV - 1);
    e.blank = (pos < DEAD_CYCLES)
           || (dig == 0 && s == 0)
           || (dig == 1 && h == 0)
           || (dig == 2 && h == 0 && t == 0);
    sb.push_back(e);

    if (rst) begin
      m_cyc = 0;
      m_res = 1'b0;
    end else begin
      m_cyc = m_cyc + 1;
      if (clr)                m_res = 1'b0;
      else if (rv)            m_res = 1'b1;
      else if (ev && m_res)   m_res = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] msd, input logic [7:0] alu,
                      input logic isg, input logic asg);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, msd, alu, isg, asg);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    reset            = 1'b1;
    bus.entry_event  = 1'b0;
    bus.result_valid = 1'b0;
    bus.clear        = 1'b0;
    bus.ab_msd       = 4'd0;
    bus.alu_out_hi   = 8'h00;
    bus.input_sign   = 1'b0;
    bus.alu_sign     = 1'b0;
    m_cyc            = 0;
    m_res            = 1'b0;
    @(posedge clk);
    #1;

    // Free run in SHOW_INPUT with a negative operand 3x.
    idle(40, 4'd3, 8'h00, 1'b1, 1'b0);

    // Result 000 positive: only units lit.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
    idle(32, 4'd3, 8'h00, 1'b1, 1'b0);
    // Interior zero shown.
    idle(32, 4'd3, 8'h10, 1'b1, 1'b1);
    // Leading zero in hundreds only.
    idle(32, 4'd3, 8'h05, 1'b1, 1'b0);

    // Simultaneous events.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 8'h42, 1'b0, 1'b1);   // clear wins
    idle(5, 4'd7, 8'h42, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 8'h42, 1'b0, 1'b1);   // result wins
    idle(5, 4'd7, 8'h42, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 8'h42, 1'b0, 1'b1);   // back to input
    idle(5, 4'd7, 8'h42, 1'b0, 1'b1);

    // Reset mid-scan at tens digit, prescaler 5, with pending pulses.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h99, 1'b1, 1'b1);
    while ((m_cyc % 32) != 21) idle(1, 4'd0, 8'h99, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'h99, 1'b1, 1'b1);
    idle(12, 4'd0, 8'h99, 1'b1, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] hn, tn, mn;
      hn = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      tn = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      mn = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 11) == 0),
           mn, {hn, tn}, 1'($urandom), 1'($urandom));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_display_scan_controller
`default_nettype wire
